// File: rtl/sram_responder_pkg.sv
// Shared definitions for the SRAM responder: data widths, the reserved token and FSM state codes.
// No logic here apart from the request-acceptance helper.
// Imported by sram_responder and its testbench.
package sram_responder_pkg;

  localparam int MEM_ADDR_W  = 16;
  localparam int MEM_VALUE_W = 16;
  localparam int TOKEN_W     = 32;
  localparam int RAM_ADDR_W  = MEM_ADDR_W + 2;

  typedef logic [MEM_ADDR_W-1:0]  mem_addr_t;
  typedef logic [MEM_VALUE_W-1:0] mem_value_t;
  typedef logic [TOKEN_W-1:0]     token_t;

  // Reset value of ram_mem_act. A request carrying this token is never served.
  localparam token_t RESERVED_TOKEN = 32'hFFFF_FFFF;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RD_SETUP  = 3'd1;
  localparam logic [2:0] ST_RD_SAMPLE = 3'd2;
  localparam logic [2:0] ST_WR_SETUP  = 3'd3;
  localparam logic [2:0] ST_WR_PULSE  = 3'd4;
  localparam logic [2:0] ST_WR_HOLD   = 3'd5;

  // A token equal to the last completed one means the controller has not moved on yet.
  function automatic logic req_accept(input logic   need,
                                      input token_t act,
                                      input token_t last_act,
                                      input logic   rd,
                                      input logic   wr);
    return need && (act != last_act) && (act != RESERVED_TOKEN) && (rd || wr);
  endfunction

endpackage

// File: rtl/sram_responder.sv
// Single-port async SRAM responder: serves one read or write per request token, all pins registered.
// Latency: read 3 edges / write 4 edges from acceptance (4 / 5 with RAM_WAIT_STATE_EN defined).
// Backpressure: requests are only accepted in IDLE; the controller holds them until ram_mem_act echoes the token.
module sram_responder
  import sram_responder_pkg::*;
#(
  parameter logic [1:0] BANK_SEL = 2'b00
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  need_to_work,
  input  logic [TOKEN_W-1:0]    mem_act,
  input  logic                  mem_rd,
  input  logic                  mem_wr,
  input  logic [MEM_ADDR_W-1:0] addr,
  input  logic [MEM_VALUE_W-1:0] wr_data,
  output logic [TOKEN_W-1:0]    ram_mem_act,
  output logic [MEM_VALUE_W-1:0] ram_feedback,
  output logic [RAM_ADDR_W-1:0] ram_addr,
  output logic [MEM_VALUE_W-1:0] ram_data_out,
  input  logic [MEM_VALUE_W-1:0] ram_data_in,
  output logic                  ram_data_oe,
  output logic                  ram_en_n,
  output logic                  ram_oe_n,
  output logic                  ram_we_n
);

  logic [2:0] state;
  token_t     tok_q;
`ifdef RAM_WAIT_STATE_EN
  logic       wait_q;
`endif

  // Every pin is a flop; the latched address and write data live directly in ram_addr / ram_data_out.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= ST_IDLE;
      tok_q        <= RESERVED_TOKEN;
      ram_mem_act  <= RESERVED_TOKEN;
      ram_feedback <= '0;
      ram_addr     <= '0;
      ram_data_out <= '0;
      ram_data_oe  <= 1'b0;
      ram_en_n     <= 1'b1;
      ram_oe_n     <= 1'b1;
      ram_we_n     <= 1'b1;
`ifdef RAM_WAIT_STATE_EN
      wait_q       <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_accept(need_to_work, mem_act, ram_mem_act, mem_rd, mem_wr)) begin
            tok_q    <= mem_act;
            ram_addr <= {BANK_SEL, addr};
            ram_en_n <= 1'b0;
            if (mem_wr) begin
              state        <= ST_WR_SETUP;
              ram_data_out <= wr_data;
              ram_data_oe  <= 1'b1;
              ram_we_n     <= 1'b1;
            end else begin
              state    <= ST_RD_SETUP;
              ram_oe_n <= 1'b0;
            end
          end
        end

        ST_RD_SETUP: state <= ST_RD_SAMPLE;

        ST_RD_SAMPLE: begin
`ifdef RAM_WAIT_STATE_EN
          if (!wait_q) begin
            wait_q <= 1'b1;
          end else begin
            wait_q       <= 1'b0;
            ram_feedback <= ram_data_in;
            ram_mem_act  <= tok_q;
            ram_en_n     <= 1'b1;
            ram_oe_n     <= 1'b1;
            state        <= ST_IDLE;
          end
`else
          ram_feedback <= ram_data_in;
          ram_mem_act  <= tok_q;
          ram_en_n     <= 1'b1;
          ram_oe_n     <= 1'b1;
          state        <= ST_IDLE;
`endif
        end

        ST_WR_SETUP: begin
          ram_we_n <= 1'b0;
          state    <= ST_WR_PULSE;
        end

        ST_WR_PULSE: begin
`ifdef RAM_WAIT_STATE_EN
          if (!wait_q) begin
            wait_q <= 1'b1;
          end else begin
            wait_q   <= 1'b0;
            ram_we_n <= 1'b1;
            state    <= ST_WR_HOLD;
          end
`else
          ram_we_n <= 1'b1;
          state    <= ST_WR_HOLD;
`endif
        end

        // Data and address stay driven one cycle past the we_n rising edge for hold time.
        ST_WR_HOLD: begin
          ram_feedback <= ram_data_out;
          ram_mem_act  <= tok_q;
          ram_data_oe  <= 1'b0;
          ram_en_n     <= 1'b1;
          state        <= ST_IDLE;
        end

        default: begin
          state       <= ST_IDLE;
          ram_data_oe <= 1'b0;
          ram_en_n    <= 1'b1;
          ram_oe_n    <= 1'b1;
          ram_we_n    <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sram_responder.sv
// Bench for sram_responder: directed timing cases plus random traffic against a behavioural SRAM and scoreboard.
module tb_sram_responder;
  import sram_responder_pkg::*;

  localparam logic [1:0] BANK = 2'b10;
`ifdef RAM_WAIT_STATE_EN
  localparam int EXTRA = 1;
`else
  localparam int EXTRA = 0;
`endif
  localparam int RD_LAT = 3 + EXTRA;
  localparam int WR_LAT = 4 + EXTRA;
  localparam int WE_W   = 1 + EXTRA;

  logic        clk;
  logic        rst;
  logic        need_to_work;
  logic [31:0] mem_act;
  logic        mem_rd;
  logic        mem_wr;
  logic [15:0] addr;
  logic [15:0] wr_data;
  logic [31:0] ram_mem_act;
  logic [15:0] ram_feedback;
  logic [17:0] ram_addr;
  logic [15:0] ram_data_out;
  logic [15:0] ram_data_in;
  logic        ram_data_oe;
  logic        ram_en_n;
  logic        ram_oe_n;
  logic        ram_we_n;

  sram_responder #(.BANK_SEL(BANK)) dut (
    .clk(clk), .rst(rst), .need_to_work(need_to_work), .mem_act(mem_act),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .addr(addr), .wr_data(wr_data),
    .ram_mem_act(ram_mem_act), .ram_feedback(ram_feedback), .ram_addr(ram_addr),
    .ram_data_out(ram_data_out), .ram_data_in(ram_data_in), .ram_data_oe(ram_data_oe),
    .ram_en_n(ram_en_n), .ram_oe_n(ram_oe_n), .ram_we_n(ram_we_n)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Behavioural SRAM: 16 words aliased on the low address nibble, written while we_n is low.
  function automatic logic [15:0] init_pat(input logic [3:0] i);
    return 16'hBEEF ^ {4{i ^ 4'd4}};
  endfunction

  logic [15:0] sram [16];
  logic [15:0] written = '0;
  always @(posedge clk) begin
    if (!ram_en_n && !ram_we_n && ram_data_oe) begin
      sram[ram_addr[3:0]]    <= ram_data_out;
      written[ram_addr[3:0]] <= 1'b1;
    end
  end
  assign ram_data_in = (!ram_en_n && !ram_oe_n) ?
                       (written[ram_addr[3:0]] ? sram[ram_addr[3:0]] : init_pat(ram_addr[3:0])) :
                       16'hDEAD;

  // Reference model: what every served request must return, in service order.
  typedef struct packed {
    logic [31:0] tok;
    logic [15:0] val;
  } exp_t;
  exp_t        sb_q[$];
  logic [15:0] ref_mem [16];

  task automatic issue(input logic rd, input logic wr, input logic [15:0] a,
                       input logic [15:0] d, input logic [31:0] tok);
    exp_t e;
    e.tok = tok;
    if (wr) begin
      ref_mem[a[3:0]] = d;
      e.val = d;
    end else begin
      e.val = ref_mem[a[3:0]];
    end
    sb_q.push_back(e);
  endtask

  task automatic drive(input logic need, input logic rd, input logic wr, input logic [15:0] a,
                       input logic [15:0] d, input logic [31:0] tok);
    need_to_work = need;
    mem_rd  = rd;
    mem_wr  = wr;
    addr    = a;
    wr_data = d;
    mem_act = tok;
  endtask

  task automatic wait_done(input logic [31:0] tok, input int budget, output int edges);
    edges = 0;
    while (ram_mem_act !== tok && edges < budget) begin
      @(posedge clk); #1;
      edges++;
    end
    if (ram_mem_act !== tok) begin
      total++;
      bad++;
      $display("FAIL timeout: token %0h not completed, ram_mem_act=%0h", tok, ram_mem_act);
    end
  endtask

  // Monitor: pops the scoreboard on each completion and checks pin-level rules every cycle.
  logic [31:0] last_act = '1;
  int we_cnt = 0;
  int oe_cnt = 0;
  always @(negedge clk) begin
    if (!rst) begin
      last_act = ram_mem_act;
      we_cnt = 0;
      oe_cnt = 0;
    end else begin
      if (ram_mem_act !== last_act && ram_mem_act !== RESERVED_TOKEN) begin
        if (sb_q.size() == 0) begin
          check("sb_unexpected_completion", ram_mem_act, last_act);
        end else begin
          exp_t e;
          e = sb_q.pop_front();
          check("sb_token", ram_mem_act, e.tok);
          check("sb_feedback", ram_feedback, e.val);
        end
      end
      last_act = ram_mem_act;
      if (!ram_oe_n) check("no_contention", ram_data_oe, 0);
      if (!ram_en_n) check("bank_sel", ram_addr[17:16], BANK);
      if (!ram_we_n) we_cnt++;
      else if (we_cnt != 0) begin
        check("we_width", we_cnt, WE_W);
        we_cnt = 0;
      end
      if (!ram_oe_n) oe_cnt++;
      else if (oe_cnt != 0) begin
        check("oe_width", oe_cnt, RD_LAT - 1);
        oe_cnt = 0;
      end
    end
  end

  initial begin
    int   n;
    logic seen;
    logic [WR_LAT:1] got_oe, got_we, exp_oe, exp_we;

    for (int i = 0; i < 16; i++) ref_mem[i] = init_pat(4'(i));
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0);
    rst = 1'b1;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_en_n", ram_en_n, 1);
    check("rst_oe_n", ram_oe_n, 1);
    check("rst_we_n", ram_we_n, 1);
    check("rst_data_oe", ram_data_oe, 0);
    check("rst_addr", ram_addr, 0);
    check("rst_data_out", ram_data_out, 0);
    check("rst_feedback", ram_feedback, 0);
    check("rst_mem_act", ram_mem_act, 32'hFFFF_FFFF);

    // Read of 0x8004 returning BEEF
    @(negedge clk) rst = 1'b1;
    @(negedge clk);
    issue(1'b1, 1'b0, 16'h8004, 16'h0, 32'd5);
    drive(1'b1, 1'b1, 1'b0, 16'h8004, 16'h0, 32'd5);
    @(posedge clk); #1;
    check("rd_oe_low", ram_oe_n, 0);
    check("rd_en_low", ram_en_n, 0);
    check("rd_addr", ram_addr, {BANK, 16'h8004});
    for (int k = 2; k < RD_LAT; k++) begin
      @(posedge clk); #1;
      check("rd_pending", ram_mem_act, 32'hFFFF_FFFF);
    end
    @(posedge clk); #1;
    check("rd_done_act", ram_mem_act, 32'd5);
    check("rd_done_data", ram_feedback, 16'hBEEF);
    check("rd_oe_released", ram_oe_n, 1);

    // Write 0x1234 to 0x0010, back-to-back with the read
    @(negedge clk);
    issue(1'b0, 1'b1, 16'h0010, 16'h1234, 32'd6);
    drive(1'b1, 1'b0, 1'b1, 16'h0010, 16'h1234, 32'd6);
    for (int k = 1; k <= WR_LAT; k++) begin
      @(posedge clk); #1;
      got_oe[k] = ram_data_oe;
      got_we[k] = ram_we_n;
      exp_oe[k] = (k < WR_LAT);
      exp_we[k] = !(k >= 2 && k < 2 + WE_W);
    end
    check("wr_data_oe_seq", got_oe, exp_oe);
    check("wr_we_n_seq", got_we, exp_we);
    check("wr_done_act", ram_mem_act, 32'd6);
    check("wr_done_data", ram_feedback, 16'h1234);

    // Completed token left on the bus must not start another access
    seen = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
      if (!ram_en_n) seen = 1'b1;
    end
    check("held_token_idle", seen, 0);

    // rd+wr together is a write; a token change mid-access waits for IDLE
    @(negedge clk);
    issue(1'b0, 1'b1, 16'h0023, 16'hCAFE, 32'd7);
    drive(1'b1, 1'b1, 1'b1, 16'h0023, 16'hCAFE, 32'd7);
    @(posedge clk); #1;
    check("both_is_write_we", ram_we_n, 1);
    check("both_is_write_oe", ram_data_oe, 1);
    check("both_is_write_rd", ram_oe_n, 1);
    @(negedge clk);
    issue(1'b1, 1'b0, 16'h0003, 16'h0, 32'd8);
    drive(1'b1, 1'b1, 1'b0, 16'h0003, 16'h0, 32'd8);
    wait_done(32'd8, 30, n);
    check("mid_change_latency", n, WR_LAT + RD_LAT - 1);

    // Reset during the write pulse
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b1, 16'h0005, 16'h5555, 32'd9);
    @(posedge clk);
    @(posedge clk); #1;
    check("abort_we_was_low", ram_we_n, 0);
    #1 rst = 1'b0;
    #1;
    check("abort_we_n", ram_we_n, 1);
    check("abort_data_oe", ram_data_oe, 0);
    check("abort_en_n", ram_en_n, 1);
    check("abort_mem_act", ram_mem_act, 32'hFFFF_FFFF);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;

    // Random traffic
    for (int i = 0; i < 300; i++) begin
      int          kind;
      logic        rd, wr;
      logic [15:0] a, d;
      logic [31:0] tok;
      kind = $urandom_range(0, 9);
      a    = 16'($urandom);
      d    = 16'($urandom);
      @(negedge clk);
      if (kind <= 1) begin
        // Reserved token, already-completed token, or no access type: must be ignored
        case ($urandom_range(0, 2))
          0:       drive(1'b1, 1'b1, 1'($urandom), a, d, RESERVED_TOKEN);
          1:       drive(1'b1, 1'($urandom), 1'b1, a, d, ram_mem_act);
          default: drive(1'b1, 1'b0, 1'b0, a, d, 32'h8000_0000 + 32'(i));
        endcase
        seen = 1'b0;
        repeat (4) begin
          @(posedge clk); #1;
          if (!ram_en_n) seen = 1'b1;
        end
        check("ignored_req", seen, 0);
      end else begin
        if (kind == 2) begin
          drive(1'b0, 1'b1, 1'b1, a, d, 32'h4000_0000 + 32'(i));
          repeat ($urandom_range(1, 3)) @(negedge clk);
        end
        wr  = 1'($urandom);
        rd  = !wr || 1'($urandom);
        tok = 32'h100 + 32'(i);
        issue(rd, wr, a, d, tok);
        drive(1'b1, rd, wr, a, d, tok);
        wait_done(tok, 30, n);
        check("b2b_latency", n, wr ? WR_LAT : RD_LAT);
      end
    end

    @(negedge clk);
    drive(1'b0, 1'b0, 1'b0, 16'h0, 16'h0, 32'h0);
    repeat (3) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/sram_responder.md
SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
REQ-001 SHALL have parameter BANK_SEL, default 2'b00, driven on ram_addr[17:16] for every access.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port need_to_work  input  1  access request from the RAM controller for this bank.
REQ-005 SHALL have port mem_act  input  32  action token identifying the request.
REQ-006 SHALL have ports mem_rd, mem_wr  input  1 each  access type.
REQ-007 SHALL have port addr  input  16  word address; bits [15:0] drive ram_addr[15:0].
REQ-008 SHALL have port wr_data  input  16  write value.
REQ-009 SHALL have port ram_mem_act  output  32  token of the last completed access.
REQ-010 SHALL have port ram_feedback  output  16  read data, or write data echoed, of the last completed access.
REQ-011 SHALL have ports ram_addr  output  18; ram_data_out  output  16; ram_data_in  input  16; ram_data_oe  output  1 (top-level tristate).
REQ-012 SHALL have ports ram_en_n, ram_oe_n, ram_we_n  output  1 each  SRAM strobes, active-low.

Function
REQ-013 SHALL register every output; no combinational path from inputs to SRAM pins.
REQ-014 SHALL implement states IDLE, RD_SETUP, RD_SAMPLE, WR_SETUP, WR_PULSE, WR_HOLD.
REQ-015 SHALL accept a request in IDLE only: need_to_work=1, mem_act!=ram_mem_act, and mem_rd|mem_wr; it latches addr, wr_data, type and token at that edge.
REQ-016 SHALL ignore a request whose token equals ram_mem_act, which marks it as already completed.
REQ-017 SHALL ignore need_to_work and all request inputs while not in IDLE; latched values hold.
REQ-018 SHALL give mem_wr priority when mem_rd and mem_wr are both 1.
REQ-019 Read: acceptance edge -> RD_SETUP with en_n=0, oe_n=0, addr driven; next edge -> RD_SAMPLE; next edge samples ram_data_in into ram_feedback, sets ram_mem_act to the token, restores en_n=oe_n=1 and returns to IDLE. Latency is 3 edges including acceptance.
REQ-020 Write: acceptance -> WR_SETUP with en_n=0, data_oe=1, we_n=1; -> WR_PULSE with we_n=0; -> WR_HOLD with we_n=1, data and addr held; next edge sets ram_feedback=wr_data and ram_mem_act=token, drops data_oe and en_n, and returns to IDLE. Latency is 4 edges.
REQ-021 SHALL keep ram_data_oe=0 whenever ram_oe_n=0 (no bus contention).
REQ-022 SHALL allow a new request to be accepted on the edge after returning to IDLE (back-to-back).
REQ-023 Token 32'hFFFFFFFF is reserved; a request carrying it is never accepted.

Reset
REQ-024 SHALL, on rst=0, immediately force state=IDLE, ram_en_n=ram_oe_n=ram_we_n=1, ram_data_oe=0, ram_addr=0, ram_data_out=0, ram_feedback=0, ram_mem_act=32'hFFFFFFFF.
REQ-025 SHALL abort a reset mid-access without updating ram_mem_act; we_n rises asynchronously.

Configuration
REQ-026 SHALL, with macro RAM_WAIT_STATE_EN defined, hold RD_SAMPLE and WR_PULSE 2 cycles each (read 4 edges, write 5 edges) using a 1-bit wait counter.
REQ-027 SHALL, without RAM_WAIT_STATE_EN, use the single-cycle timing of REQ-019/020 with no counter logic.

Structure
REQ-028 State encodings, the reserved-token constant and MemAddr/MemValue widths SHALL live in the shared definitions package/header.
REQ-029 No sub-module; the single FSM and datapath live in sram_responder.

Verification
REQ-030 Reset release, need_to_work=1, mem_rd=1, addr=16'h8004, mem_act=5, ram_data_in=16'hBEEF -> oe_n low 2 cycles; ram_feedback=BEEF and ram_mem_act=5 after edge 3.
REQ-031 mem_wr=1, addr=16'h0010, wr_data=16'h1234, act=6 -> we_n low exactly 1 cycle; data_oe spans SETUP..HOLD; ram_mem_act=6 after edge 4; ram_feedback=1234.
REQ-032 Request held with act=6 after completion -> no strobe activity.
REQ-033 mem_rd=mem_wr=1, act=7 -> write sequence; act changes to 8 mid-access -> ignored until IDLE, then served.
REQ-034 rst low during WR_PULSE -> we_n=1, data_oe=0 at once; ram_mem_act=FFFFFFFF.
REQ-035 With RAM_WAIT_STATE_EN: the REQ-030 read completes after edge 4, and we_n is low 2 cycles on write.
